alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand-fetch stage directly upstream of the ALU. Holds the 32×32-bit general register bank and selects register or sign-extended immediate operands. Registers the operands and the 4-bit ALU operation into a one-deep pipeline latch that drives the ALU's `inp1`, `inp2` and `operation` inputs. Write-back from later stages enters through a single write port.

## Interface
- `DATA_W`, 32, register/operand width
- `NREGS`, 32, number of general registers (address width = log2(NREGS))
- `IMM_W`, 16, immediate field width, sign-extended to DATA_W
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `valid_in` in 1: decoded instruction present this cycle
- `rs_addr` in 5: source register for `inp1`
- `rt_addr` in 5: source register for `inp2`
- `imm` in IMM_W: immediate field
- `use_imm` in 1: 1 = `inp2` from sign-extended `imm`; 0 = from `rt_addr`
- `op_in` in 4: ALU operation code
- `stall` in 1: downstream not ready; hold latch
- `flush` in 1: discard latched instruction
- `wr_en` in 1: write-back enable
- `wr_addr` in 5: write-back register
- `wr_data` in DATA_W: write-back value
- `inp1` out DATA_W: latched operand 1 to ALU
- `inp2` out DATA_W: latched operand 2 to ALU
- `operation` out 4: latched ALU op
- `valid_out` out 1: latch holds a live instruction

## Operation
- Register 0 always reads 0; writes to it are ignored.
- Write port: on the edge with `wr_en=1` and `wr_addr≠0`, `bank[wr_addr] <= wr_data`. Writes proceed regardless of `stall`/`flush`.
- Read: combinational from the bank. `op2 = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : bank[rt_addr]`.
- Latch update priority on each edge:
  1. `reset`: `inp1`/`inp2` = 0, `operation` = 4'b0000, `valid_out` = 0; all bank entries = 0.
  2. `flush`: `valid_out <= 0`. Data fields may keep or take new values; they are don't-care when invalid. Flush wins over stall.
  3. `stall`: all latch outputs hold.
  4. Otherwise: `inp1 <= op1`, `inp2 <= op2`, `operation <= op_in`, `valid_out <= valid_in`.
- When `valid_in=0` and not stalled, the data fields still load. Consumers must gate on `valid_out`.
- Out-of-range addresses (≥ NREGS when NREGS < 32) read as 0 and are not written.

## Timing
- Latency is 1 cycle: operands are sampled on edge N and visible on `inp1`/`inp2` after edge N.
- Write-to-read is governed by the macro below (same-edge hazard).
- Read after a completed write (a later cycle) always returns the new value.
- Reset mid-stall clears the latch; the stall is not remembered.
- There is no backpressure to the decoder other than the externally shared `stall`. An instruction presented during a stall is dropped unless the upstream stage holds it, which is upstream's responsibility.

## Configuration
- `ALU_OPERAND_BYPASS_EN`
  - **Defined:** if `wr_en`, `wr_addr≠0` and `wr_addr` equals `rs_addr` (resp. `rt_addr` with `use_imm=0`) in the same cycle, the latch captures `wr_data` instead of the stale bank value.
  - **Undefined:** the latch captures the pre-write bank value. Software/hazard logic must insert a bubble.

## Structure
- Shared package `kgp_risc_pkg` holds:
  - ALU op constants: `ALU_ADD`=4'b0000, `ALU_AND`=4'b0001, `ALU_XOR`=4'b0010, `ALU_COMP`=4'b0011, `ALU_SHLL`=4'b0100, `ALU_SHRL`=4'b0101, `ALU_SHRA`=4'b0110, `ALU_LTZ`=4'b0111, `ALU_EQZ`=4'b1000.
  - `DATA_W` and the register-address width.
- One sub-module, `reg_bank`: a 2-read/1-write array with hardwired-zero R0 and synchronous reset. The operand mux, bypass and latch live in the top.

## Test plan
- Reset held 2 cycles then released, no writes:
  - → `inp1=0`, `inp2=0`, `operation=0`, `valid_out=0`.
  - Any read returns 0.
- Write R5=105, R6=110, then issue rs=5, rt=6, op=`ALU_AND`, valid → next cycle `inp1=105`, `inp2=110`, `operation=4'b0001`, `valid_out=1`.
- Same cycle: write R7=42 and issue rs=7, use_imm=1, imm=16'hFFFF, op=`ALU_ADD`:
  - With macro: `inp1=42`.
  - Without macro: `inp1=0`.
  - Both cases: `inp2=32'hFFFFFFFF`.
- Write R0=99, then read rs=0 → `inp1=0`.
- Latch holds rs=5 (105). Assert `stall` for 3 cycles while changing rs/op and writing R5=1:
  - → outputs stay 105 / old op throughout the stall.
  - After release and re-issue, `inp1=1`.
- `stall=1` and `flush=1` together → `valid_out=0` next cycle. Then deassert both with `valid_in=1` → `valid_out=1`.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared constants for the KGP RISC datapath: ALU operation codes and
// datapath/register-file dimensions.
package kgp_risc_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 16;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_COMP = 4'b0011;
  localparam logic [3:0] ALU_SHLL = 4'b0100;
  localparam logic [3:0] ALU_SHRL = 4'b0101;
  localparam logic [3:0] ALU_SHRA = 4'b0110;
  localparam logic [3:0] ALU_LTZ  = 4'b0111;
  localparam logic [3:0] ALU_EQZ  = 4'b1000;

endpackage

// File: rtl/alu_operand_stage_reg_bank.sv
// General register bank: two combinational read ports, one write port,
// R0 hardwired to zero, synchronous clear on reset.
module reg_bank #(
  parameter int DATA_W = kgp_risc_pkg::DATA_W,
  parameter int NREGS  = kgp_risc_pkg::NREGS,
  parameter int ADDR_W = kgp_risc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_ok;
  logic              w_rd_ok_a;
  logic              w_rd_ok_b;

  // Address 0 and anything beyond the populated registers never hit storage.
  assign w_wr_ok   = wr_en && (wr_addr != '0) && (int'(wr_addr) < NREGS);
  assign w_rd_ok_a = (rd_addr_a != '0) && (int'(rd_addr_a) < NREGS);
  assign w_rd_ok_b = (rd_addr_b != '0) && (int'(rd_addr_b) < NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = w_rd_ok_a ? r_mem[rd_addr_a] : '0;
  assign rd_data_b = w_rd_ok_b ? r_mem[rd_addr_b] : '0;

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the ALU: register bank, immediate sign-extension
// and a one-deep operand latch. Define ALU_OPERAND_BYPASS_EN to forward a
// same-cycle write-back into the captured operands.
module alu_operand_stage #(
  parameter int DATA_W = kgp_risc_pkg::DATA_W,
  parameter int NREGS  = kgp_risc_pkg::NREGS,
  parameter int IMM_W  = kgp_risc_pkg::IMM_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [kgp_risc_pkg::ADDR_W-1:0] rs_addr,
  input  logic [kgp_risc_pkg::ADDR_W-1:0] rt_addr,
  input  logic [IMM_W-1:0]                imm,
  input  logic                            use_imm,
  input  logic [3:0]                      op_in,
  input  logic                            stall,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic [kgp_risc_pkg::ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               inp1,
  output logic [DATA_W-1:0]               inp2,
  output logic [3:0]                      operation,
  output logic                            valid_out
);

  localparam int ADDR_W = kgp_risc_pkg::ADDR_W;

  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_wr_live;

  logic [DATA_W-1:0] r_inp1;
  logic [DATA_W-1:0] r_inp2;
  logic [3:0]        r_operation;
  logic              r_valid;

  reg_bank #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_reg_bank (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rs_addr),
    .rd_addr_b (rt_addr),
    .rd_data_a (w_rs_data),
    .rd_data_b (w_rt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  assign w_imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  // A write that the bank will actually commit this edge.
  assign w_wr_live = wr_en && (wr_addr != '0) && (int'(wr_addr) < NREGS);

`ifdef ALU_OPERAND_BYPASS_EN
  always_comb begin
    w_op1 = w_rs_data;
    w_op2 = use_imm ? w_imm_ext : w_rt_data;
    if (w_wr_live && (wr_addr == rs_addr)) begin
      w_op1 = wr_data;
    end
    if (w_wr_live && !use_imm && (wr_addr == rt_addr)) begin
      w_op2 = wr_data;
    end
  end
`else
  always_comb begin
    w_op1 = w_rs_data;
    w_op2 = use_imm ? w_imm_ext : w_rt_data;
  end

  logic w_unused_wr_live;
  assign w_unused_wr_live = w_wr_live;
`endif

  // Flush only kills validity; the data fields are don't-care once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inp1      <= '0;
      r_inp2      <= '0;
      r_operation <= 4'b0000;
      r_valid     <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_inp1      <= w_op1;
      r_inp2      <= w_op2;
      r_operation <= op_in;
      r_valid     <= valid_in;
    end
  end

  assign inp1      = r_inp1;
  assign inp2      = r_inp2;
  assign operation = r_operation;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written reset-in-stall
// sequence, then randomized traffic against a reference model.
module tb_alu_operand_stage;
  import kgp_risc_pkg::*;

`ifdef ALU_OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  rs_addr, rt_addr;
  logic [15:0] imm;
  logic        use_imm;
  logic [3:0]  op_in;
  logic        stall, flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] inp1, inp2;
  logic [3:0]  operation;
  logic        valid_out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .imm       (imm),
    .use_imm   (use_imm),
    .op_in     (op_in),
    .stall     (stall),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .inp1      (inp1),
    .inp2      (inp2),
    .operation (operation),
    .valid_out (valid_out)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        stall;
    logic        flush;
    logic        chk_data;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [3:0]  eop;
    logic        ev;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; valid_in = 1'b0; rs_addr = '0; rt_addr = '0; imm = '0;
    use_imm = 1'b0; op_in = '0; stall = 1'b0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] im, input logic ui, input logic [3:0] op,
                         input logic st, input logic fl, input logic cd,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [3:0] eop, input logic ev);
    vec_t t;
    t.wr_en = w; t.wr_addr = wa; t.wr_data = wd; t.valid = v; t.rs = rs; t.rt = rt;
    t.imm = im; t.use_imm = ui; t.op = op; t.stall = st; t.flush = fl;
    t.chk_data = cd; t.e1 = e1; t.e2 = e2; t.eop = eop; t.ev = ev;
    vecs.push_back(t);
  endtask

  // Reference model state
  logic [31:0] m_bank [32];
  logic [31:0] m_inp1, m_inp2;
  logic [3:0]  m_op;
  logic        m_valid;
  logic        m_known;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_bank[a];
  endfunction

  task automatic model_step();
    logic [31:0] op1, op2;
    logic        hit;
    hit = wr_en && (wr_addr != 5'd0);
    op1 = (BYP && hit && wr_addr == rs_addr) ? wr_data : m_read(rs_addr);
    if (use_imm) op2 = 32'(signed'(imm));
    else op2 = (BYP && hit && wr_addr == rt_addr) ? wr_data : m_read(rt_addr);
    if (reset) begin
      m_inp1 = 0; m_inp2 = 0; m_op = 0; m_valid = 0; m_known = 1;
      for (int i = 0; i < 32; i++) m_bank[i] = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_known = 0;
      end else if (!stall) begin
        m_inp1 = op1; m_inp2 = op2; m_op = op_in; m_valid = valid_in; m_known = 1;
      end
      if (hit) m_bank[wr_addr] = wr_data;
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    check("reset_inp1", inp1, 32'd0);
    check("reset_inp2", inp2, 32'd0);
    check("reset_op", {28'd0, operation}, 32'd0);
    check("reset_valid", {31'd0, valid_out}, 32'd0);

    drive_idle();
    rs_addr = 5'd3; rt_addr = 5'd9; valid_in = 1'b1;
    tick();
    check("rd0_inp1", inp1, 32'd0);
    check("rd0_inp2", inp2, 32'd0);

    //      w  wa  wd            v  rs  rt  imm       ui op        st fl cd e1                         e2                         eop       ev
    add_vec(1, 5,  32'd105,      0, 0,  0,  16'h0,    0, ALU_ADD,  0, 0, 1, 32'd0,                     32'd0,                     ALU_ADD,  0);
    add_vec(1, 6,  32'd110,      0, 0,  0,  16'h0,    0, ALU_ADD,  0, 0, 1, 32'd0,                     32'd0,                     ALU_ADD,  0);
    add_vec(0, 0,  32'd0,        1, 5,  6,  16'h0,    0, ALU_AND,  0, 0, 1, 32'd105,                   32'd110,                   ALU_AND,  1);
    add_vec(1, 7,  32'd42,       1, 7,  0,  16'hFFFF, 1, ALU_ADD,  0, 0, 1, BYP ? 32'd42 : 32'd0,      32'hFFFF_FFFF,             ALU_ADD,  1);
    add_vec(1, 0,  32'd99,       1, 7,  0,  16'h0,    0, ALU_XOR,  0, 0, 1, 32'd42,                    32'd0,                     ALU_XOR,  1);
    add_vec(0, 0,  32'd0,        1, 0,  0,  16'h0,    0, ALU_ADD,  0, 0, 1, 32'd0,                     32'd0,                     ALU_ADD,  1);
    add_vec(0, 0,  32'd0,        1, 5,  6,  16'h0,    0, ALU_ADD,  0, 0, 1, 32'd105,                   32'd110,                   ALU_ADD,  1);
    add_vec(1, 5,  32'd1,        1, 7,  6,  16'h0,    0, ALU_SHLL, 1, 0, 1, 32'd105,                   32'd110,                   ALU_ADD,  1);
    add_vec(0, 0,  32'd0,        1, 6,  6,  16'h0,    0, ALU_LTZ,  1, 0, 1, 32'd105,                   32'd110,                   ALU_ADD,  1);
    add_vec(0, 0,  32'd0,        0, 0,  6,  16'h0,    0, ALU_EQZ,  1, 0, 1, 32'd105,                   32'd110,                   ALU_ADD,  1);
    add_vec(0, 0,  32'd0,        1, 5,  6,  16'h0,    0, ALU_SHRA, 0, 0, 1, 32'd1,                     32'd110,                   ALU_SHRA, 1);
    add_vec(0, 0,  32'd0,        1, 6,  5,  16'h0,    0, ALU_COMP, 1, 1, 0, 32'd0,                     32'd0,                     ALU_ADD,  0);
    add_vec(0, 0,  32'd0,        1, 6,  5,  16'h0,    0, ALU_COMP, 0, 0, 1, 32'd110,                   32'd1,                     ALU_COMP, 1);
    add_vec(0, 0,  32'd0,        0, 7,  7,  16'h7FFF, 1, ALU_EQZ,  0, 0, 1, 32'd42,                    32'h0000_7FFF,             ALU_EQZ,  0);
    add_vec(0, 0,  32'd0,        1, 7,  7,  16'h8000, 1, ALU_ADD,  0, 1, 0, 32'd0,                     32'd0,                     ALU_ADD,  0);
    add_vec(1, 31, 32'hDEADBEEF, 1, 31, 31, 16'h8000, 0, ALU_XOR,  0, 0, 1, BYP ? 32'hDEADBEEF : 32'd0, BYP ? 32'hDEADBEEF : 32'd0, ALU_XOR,  1);
    add_vec(0, 0,  32'd0,        1, 31, 7,  16'h8000, 1, ALU_SHRL, 0, 0, 1, 32'hDEADBEEF,              32'hFFFF_8000,             ALU_SHRL, 1);

    foreach (vecs[i]) begin
      drive_idle();
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      valid_in = vecs[i].valid; rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
      imm = vecs[i].imm; use_imm = vecs[i].use_imm; op_in = vecs[i].op;
      stall = vecs[i].stall; flush = vecs[i].flush;
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vecs[i].ev});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_inp1", i), inp1, vecs[i].e1);
        check($sformatf("vec%0d_inp2", i), inp2, vecs[i].e2);
        check($sformatf("vec%0d_op", i), {28'd0, operation}, {28'd0, vecs[i].eop});
      end
    end

    // Reset while stalled clears the latch and bank; stall is not remembered.
    drive_idle();
    stall = 1'b1; valid_in = 1'b1; rs_addr = 5'd31; op_in = ALU_EQZ;
    tick();
    reset = 1'b1;
    tick();
    check("rst_stall_valid", {31'd0, valid_out}, 32'd0);
    check("rst_stall_inp1", inp1, 32'd0);
    check("rst_stall_op", {28'd0, operation}, 32'd0);
    drive_idle();
    valid_in = 1'b1; rs_addr = 5'd31; rt_addr = 5'd5; op_in = ALU_SHRL;
    tick();
    check("post_rst_valid", {31'd0, valid_out}, 32'd1);
    check("post_rst_inp1", inp1, 32'd0);
    check("post_rst_inp2", inp2, 32'd0);
    check("post_rst_op", {28'd0, operation}, {28'd0, ALU_SHRL});

    // Randomized traffic against the reference model.
    drive_idle();
    reset = 1'b1;
    model_step();
    tick();
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      reset    = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      valid_in = $urandom_range(0, 1);
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      use_imm  = $urandom_range(0, 1);
      imm      = 16'($urandom);
      op_in    = 4'($urandom_range(0, 8));
      model_step();
      tick();
      check($sformatf("rnd%0d_valid", c), {31'd0, valid_out}, {31'd0, m_valid});
      if (m_known) begin
        check($sformatf("rnd%0d_inp1", c), inp1, m_inp1);
        check($sformatf("rnd%0d_inp2", c), inp2, m_inp2);
        check($sformatf("rnd%0d_op", c), {28'd0, operation}, {28'd0, m_op});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
